// File: rtl/hazard_ctrl_gen2_pkg.sv
// Shared types, forward-select encoding and width helper for the
// second-generation hazard controller.
package hazard_pkg;

   // Pipeline stage a forwarding source lives in.
   typedef enum logic {
      STG_M = 1'b0,
      STG_W = 1'b1
   } stage_e;

   // Forward-select codes for the common cases.
   localparam int FWD_RF = 0;
   localparam int FWD_W0 = 1;
   localparam int FWD_M0 = 2;

   // Width of one forward select for a given number of write ports per stage.
   function automatic int fw_width(input int num_wp);
      return $clog2(2 * num_wp + 1);
   endfunction

   // Forward code for write port k of a stage:
   //   M: port 0 -> 2, port k>0 -> 2k+1
   //   W: port 0 -> 1, port k>0 -> 2k+2
   function automatic int fwd_code(input stage_e stage, input int k);
      if (stage == STG_M) return (k == 0) ? FWD_M0 : 2 * k + 1;
      else                return (k == 0) ? FWD_W0 : 2 * k + 2;
   endfunction

endpackage

// File: rtl/hazard_ctrl_gen2_if.sv
// Pipeline <-> hazard controller bundle. The pipeline (master) drives the
// register addresses and stage flags; the controller (slave) returns the
// forward selects, stalls and flushes.
interface hazard_ctrl_gen2_if #(
   parameter int NUM_SRC = 4,
   parameter int NUM_WP  = 2,
   parameter int REG_AW  = 4,
   parameter int FW      = 3
);
   logic [NUM_SRC*REG_AW-1:0] SrcRegD;
   logic [NUM_SRC-1:0]        SrcValidD;
   logic [NUM_SRC*REG_AW-1:0] SrcRegE;
   logic [NUM_SRC-1:0]        SrcValidE;
   logic [NUM_WP*REG_AW-1:0]  DstRegE;
   logic [NUM_WP*REG_AW-1:0]  DstRegM;
   logic [NUM_WP*REG_AW-1:0]  DstRegW;
   logic [NUM_WP-1:0]         RegWriteE;
   logic [NUM_WP-1:0]         RegWriteM;
   logic [NUM_WP-1:0]         RegWriteW;
   logic                      MemToRegE;
   logic                      MulStartE;
   logic                      BranchTakenE;
   logic                      PCSrcD;
   logic                      PCSrcE;
   logic                      PCSrcM;
   logic                      PCSrcW;
   logic [NUM_SRC*FW-1:0]     ForwardE;
   logic                      StallF;
   logic                      StallD;
   logic                      StallE;
   logic                      FlushD;
   logic                      FlushE;
   logic                      FlushM;

   modport master (
      output SrcRegD, SrcValidD, SrcRegE, SrcValidE,
             DstRegE, DstRegM, DstRegW, RegWriteE, RegWriteM, RegWriteW,
             MemToRegE, MulStartE, BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW,
      input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM
   );

   modport slave (
      input  SrcRegD, SrcValidD, SrcRegE, SrcValidE,
             DstRegE, DstRegM, DstRegW, RegWriteE, RegWriteM, RegWriteW,
             MemToRegE, MulStartE, BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW,
      output ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM
   );
endinterface

// File: rtl/hazard_ctrl_gen2_fwd_sel.sv
// Forward select for one execute-stage operand: compares its address against
// every M and W write port and returns the code of the first hit.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int NUM_WP = 2,
   parameter int REG_AW = 4,
   parameter int FW     = fw_width(NUM_WP)
) (
   input  logic [REG_AW-1:0]        src_reg,
   input  logic                     src_valid,
   input  logic [NUM_WP*REG_AW-1:0] dst_m,
   input  logic [NUM_WP-1:0]        we_m,
   input  logic [NUM_WP*REG_AW-1:0] dst_w,
   input  logic [NUM_WP-1:0]        we_w,
   output logic [FW-1:0]            sel
);

   logic found;

   // Priority scan: port index ascending, M before W within a port.
   // NOTE: every variable written here gets a default first, so no path can leave it holding its old value (which would infer a latch).
   always_comb begin
      sel   = FW'(FWD_RF);
      found = 1'b0;
      for (int k = 0; k < NUM_WP; k++) begin
         if (!found && src_valid && we_m[k] &&
             (src_reg == dst_m[k*REG_AW +: REG_AW])) begin
            sel   = FW'(fwd_code(STG_M, k));
            found = 1'b1;
         end
         if (!found && src_valid && we_w[k] &&
             (src_reg == dst_w[k*REG_AW +: REG_AW])) begin
            sel   = FW'(fwd_code(STG_W, k));
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_gen2.sv
// Second-generation hazard controller: operand forwarding, multi-cycle
// load-use stall, iterative-multiplier busy stall and branch/PC-write flushes.
module hazard_ctrl_gen2
   import hazard_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int NUM_WP  = 2,
   parameter int REG_AW  = 4,
   parameter int LD_LAT  = 1,
   parameter int MUL_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   hazard_ctrl_gen2_if.slave  bus
);

   localparam int FW        = fw_width(NUM_WP);
   localparam int LCW       = $clog2(LD_LAT + 1);
   // A single-cycle multiplier never busies E; keep the counter 1 bit wide.
   localparam int MCW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam bit MUL_MULTI = (MUL_LAT > 1);

   logic [LCW-1:0]        ld_cnt;
   logic [MCW-1:0]        mul_cnt;
   logic [NUM_SRC*FW-1:0] fwd_raw;
   logic                  ld_hit;
   logic                  ld_busy;
   logic                  mul_busy;
   logic                  ld_start;
   logic                  mul_start;
   logic                  br_e;
   logic                  pc_wr_pend;

   // One forward selector per execute-stage operand.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      hazard_fwd_sel #(
         .NUM_WP (NUM_WP),
         .REG_AW (REG_AW),
         .FW     (FW)
      ) u_fwd_sel (
         .src_reg   (bus.SrcRegE[i*REG_AW +: REG_AW]),
         .src_valid (bus.SrcValidE[i]),
         .dst_m     (bus.DstRegM),
         .we_m      (bus.RegWriteM),
         .dst_w     (bus.DstRegW),
         .we_w      (bus.RegWriteW),
         .sel       (fwd_raw[i*FW +: FW])
      );
   end

   // Load-use detection: any valid decode source reading a register that a
   // load in E is about to write.
   always_comb begin
      ld_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = 0; k < NUM_WP; k++) begin
            if (bus.SrcValidD[i] && bus.RegWriteE[k] &&
                (bus.SrcRegD[i*REG_AW +: REG_AW] == bus.DstRegE[k*REG_AW +: REG_AW]))
               ld_hit = 1'b1;
         end
      end
      ld_hit = ld_hit & bus.MemToRegE;
   end

   // Event qualification. A taken branch beats a load-use (the load's
   // consumer is being flushed anyway), and a busy multiplier masks both.
   always_comb begin
      ld_busy    = (ld_cnt != '0);
      mul_busy   = (mul_cnt != '0);
      pc_wr_pend = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;
      br_e       = bus.BranchTakenE & ~mul_busy;
      ld_start   = ld_hit & ~ld_busy & ~mul_busy & ~bus.BranchTakenE;
      mul_start  = bus.MulStartE & ~mul_busy & MUL_MULTI;
   end

   // Stall/flush/forward outputs, all held low while reset is asserted.
   always_comb begin
      bus.ForwardE = '0;
      bus.StallF   = 1'b0;
      bus.StallD   = 1'b0;
      bus.StallE   = 1'b0;
      bus.FlushD   = 1'b0;
      bus.FlushE   = 1'b0;
      bus.FlushM   = 1'b0;
      if (reset) begin
         bus.ForwardE = fwd_raw;
         bus.StallF   = ld_start | ld_busy | mul_busy | pc_wr_pend;
         bus.StallD   = ld_start | ld_busy | mul_busy;
         bus.StallE   = mul_busy;
         bus.FlushD   = pc_wr_pend | bus.PCSrcW | br_e;
         bus.FlushE   = ld_start | ld_busy | br_e;
         bus.FlushM   = mul_busy;
      end
   end

   // Load-use and multiply-busy down-counters.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_cnt  <= '0;
         mul_cnt <= '0;
      end else begin
         if (ld_start)     ld_cnt <= LCW'(LD_LAT - 1);
         else if (ld_busy) ld_cnt <= ld_cnt - LCW'(1);

         if (mul_start)     mul_cnt <= MCW'(MUL_LAT - 1);
         else if (mul_busy) mul_cnt <= mul_cnt - MCW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// Directed bench for hazard_ctrl_gen2. Two instances share the same stimulus:
// dut_a (LD_LAT=3, MUL_LAT=4) and dut_b (LD_LAT=4, MUL_LAT=1). Expected
// output vectors are queued as each step is driven and compared at the
// following falling edge.
module tb_hazard_ctrl_gen2;
   import hazard_pkg::*;

   localparam int NS  = 4;
   localparam int NW  = 2;
   localparam int AW  = 4;
   localparam int FWB = fw_width(NW);

   // Hazard vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM}
   localparam logic [5:0] HZ_NONE = 6'b000000;
   localparam logic [5:0] HZ_LD   = 6'b110010;
   localparam logic [5:0] HZ_MUL  = 6'b111001;
   localparam logic [5:0] HZ_BR   = 6'b000110;
   localparam logic [5:0] HZ_PC   = 6'b100100;
   localparam logic [5:0] HZ_PCW  = 6'b000100;

   typedef struct {
      string       tag;
      bit          dut_b;
      logic [17:0] val;
   } exp_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   hazard_ctrl_gen2_if #(.NUM_SRC(NS), .NUM_WP(NW), .REG_AW(AW), .FW(FWB)) bus_a ();
   hazard_ctrl_gen2_if #(.NUM_SRC(NS), .NUM_WP(NW), .REG_AW(AW), .FW(FWB)) bus_b ();

   hazard_ctrl_gen2 #(.NUM_SRC(NS), .NUM_WP(NW), .REG_AW(AW), .LD_LAT(3), .MUL_LAT(4))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   hazard_ctrl_gen2 #(.NUM_SRC(NS), .NUM_WP(NW), .REG_AW(AW), .LD_LAT(4), .MUL_LAT(1))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   assign bus_b.SrcRegD      = bus_a.SrcRegD;
   assign bus_b.SrcValidD    = bus_a.SrcValidD;
   assign bus_b.SrcRegE      = bus_a.SrcRegE;
   assign bus_b.SrcValidE    = bus_a.SrcValidE;
   assign bus_b.DstRegE      = bus_a.DstRegE;
   assign bus_b.DstRegM      = bus_a.DstRegM;
   assign bus_b.DstRegW      = bus_a.DstRegW;
   assign bus_b.RegWriteE    = bus_a.RegWriteE;
   assign bus_b.RegWriteM    = bus_a.RegWriteM;
   assign bus_b.RegWriteW    = bus_a.RegWriteW;
   assign bus_b.MemToRegE    = bus_a.MemToRegE;
   assign bus_b.MulStartE    = bus_a.MulStartE;
   assign bus_b.BranchTakenE = bus_a.BranchTakenE;
   assign bus_b.PCSrcD       = bus_a.PCSrcD;
   assign bus_b.PCSrcE       = bus_a.PCSrcE;
   assign bus_b.PCSrcM       = bus_a.PCSrcM;
   assign bus_b.PCSrcW       = bus_a.PCSrcW;

   logic [17:0] obs_a;
   logic [17:0] obs_b;
   assign obs_a = {bus_a.StallF, bus_a.StallD, bus_a.StallE, bus_a.FlushD,
                   bus_a.FlushE, bus_a.FlushM, bus_a.ForwardE};
   assign obs_b = {bus_b.StallF, bus_b.StallD, bus_b.StallE, bus_b.FlushD,
                   bus_b.FlushE, bus_b.FlushM, bus_b.ForwardE};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A multiply must never enter E while a load-use stall holds the pipe.
   always @(negedge clk) begin
      if (reset && bus_a.StallD && bus_a.FlushE && !bus_a.StallE) begin
         n_tests++;
         assert (bus_a.MulStartE === 1'b0) else begin
            n_fail++;
            $error("FAIL mul_during_ld observed=%b expected=0", bus_a.MulStartE);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      bus_a.SrcRegD      = '0;
      bus_a.SrcValidD    = '0;
      bus_a.SrcRegE      = '0;
      bus_a.SrcValidE    = '0;
      bus_a.DstRegE      = '0;
      bus_a.DstRegM      = '0;
      bus_a.DstRegW      = '0;
      bus_a.RegWriteE    = '0;
      bus_a.RegWriteM    = '0;
      bus_a.RegWriteW    = '0;
      bus_a.MemToRegE    = 1'b0;
      bus_a.MulStartE    = 1'b0;
      bus_a.BranchTakenE = 1'b0;
      bus_a.PCSrcD       = 1'b0;
      bus_a.PCSrcE       = 1'b0;
      bus_a.PCSrcM       = 1'b0;
      bus_a.PCSrcW       = 1'b0;
   endtask

   // Load r7 in E (port 0) with decode source 1 reading r7.
   task automatic load_r7(input bit on);
      bus_a.DstRegE[3:0]  = 4'd7;
      bus_a.RegWriteE     = on ? 2'b01 : 2'b00;
      bus_a.MemToRegE     = on;
      bus_a.SrcRegD[7:4]  = 4'd7;
      bus_a.SrcValidD[1]  = 1'b1;
   endtask

   task automatic expect_out(input string tag, input bit on_b,
                             input logic [5:0] hz, input logic [11:0] fwd);
      exp_t e;
      e.tag   = tag;
      e.dut_b = on_b;
      e.val   = {hz, fwd};
      sb.push_back(e);
   endtask

   task automatic sample();
      exp_t        e;
      logic [17:0] obs;
      @(negedge clk);
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = e.dut_b ? obs_b : obs_a;
         n_tests++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // Compare this cycle, then advance to just after the next rising edge.
   task automatic step();
      sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      idle();
      #1;
      // Hazard-looking inputs during reset must not reach the outputs.
      bus_a.PCSrcD       = 1'b1;
      bus_a.SrcRegE[3:0] = 4'd5;
      bus_a.SrcValidE[0] = 1'b1;
      bus_a.DstRegM[3:0] = 4'd5;
      bus_a.RegWriteM    = 2'b01;
      expect_out("rst_a", 1'b0, HZ_NONE, 12'h000);
      expect_out("rst_b", 1'b1, HZ_NONE, 12'h000);
      step();
      idle();
      reset = 1'b1;
      expect_out("post_rst_a", 1'b0, HZ_NONE, 12'h000);
      expect_out("post_rst_b", 1'b1, HZ_NONE, 12'h000);
      step();

      // Forwarding priority.
      bus_a.SrcRegE[3:0] = 4'd5;
      bus_a.SrcValidE[0] = 1'b1;
      bus_a.DstRegM[7:4] = 4'd5;
      bus_a.RegWriteM    = 2'b10;
      bus_a.DstRegW[3:0] = 4'd5;
      bus_a.RegWriteW    = 2'b01;
      expect_out("fwd_w0_over_m1", 1'b0, HZ_NONE, 12'h001);
      step();
      bus_a.RegWriteW = 2'b00;
      expect_out("fwd_m1", 1'b0, HZ_NONE, 12'h003);
      step();
      bus_a.DstRegM[3:0] = 4'd5;
      bus_a.RegWriteM    = 2'b11;
      expect_out("fwd_m0", 1'b0, HZ_NONE, 12'h002);
      step();
      bus_a.SrcRegE[11:8] = 4'd9;
      bus_a.SrcValidE[2]  = 1'b1;
      bus_a.DstRegW[7:4]  = 4'd9;
      bus_a.RegWriteW     = 2'b10;
      expect_out("fwd_w1_op2", 1'b0, HZ_NONE, 12'h102);
      step();
      bus_a.SrcValidE[0] = 1'b0;
      expect_out("fwd_invalid_src", 1'b0, HZ_NONE, 12'h100);
      step();
      idle();

      // Load-use: LD_LAT=3 on dut_a, LD_LAT=4 on dut_b.
      load_r7(1'b1);
      expect_out("ld_c0_a", 1'b0, HZ_LD, 12'h000);
      expect_out("ld_c0_b", 1'b1, HZ_LD, 12'h000);
      step();
      load_r7(1'b0);
      expect_out("ld_c1_a", 1'b0, HZ_LD, 12'h000);
      expect_out("ld_c1_b", 1'b1, HZ_LD, 12'h000);
      step();
      expect_out("ld_c2_a", 1'b0, HZ_LD, 12'h000);
      expect_out("ld_c2_b", 1'b1, HZ_LD, 12'h000);
      step();
      expect_out("ld_c3_a", 1'b0, HZ_NONE, 12'h000);
      expect_out("ld_c3_b", 1'b1, HZ_LD, 12'h000);
      step();
      // Matching address on a port whose write enable is off: no hit.
      bus_a.DstRegE[3:0] = 4'd7;
      bus_a.RegWriteE    = 2'b10;
      bus_a.MemToRegE    = 1'b1;
      expect_out("ld_we_off_a", 1'b0, HZ_NONE, 12'h000);
      expect_out("ld_we_off_b", 1'b1, HZ_NONE, 12'h000);
      step();
      idle();

      // Multiply busy (MUL_LAT=4) with a branch and a load-use arriving late.
      bus_a.MulStartE = 1'b1;
      expect_out("mul_first", 1'b0, HZ_NONE, 12'h000);
      step();
      bus_a.MulStartE = 1'b0;
      expect_out("mul_c1", 1'b0, HZ_MUL, 12'h000);
      step();
      bus_a.BranchTakenE = 1'b1;
      expect_out("mul_c2_branch", 1'b0, HZ_MUL, 12'h000);
      step();
      bus_a.BranchTakenE = 1'b0;
      load_r7(1'b1);
      expect_out("mul_c3_ldhit", 1'b0, HZ_MUL, 12'h000);
      step();
      expect_out("ld_after_mul", 1'b0, HZ_LD, 12'h000);
      step();
      load_r7(1'b0);
      expect_out("ld_after_mul_c1", 1'b0, HZ_LD, 12'h000);
      step();
      expect_out("ld_after_mul_c2", 1'b0, HZ_LD, 12'h000);
      step();
      expect_out("ld_after_mul_end", 1'b0, HZ_NONE, 12'h000);
      step();
      idle();

      // Branch and load-use together: branch wins.
      bus_a.BranchTakenE = 1'b1;
      load_r7(1'b1);
      expect_out("br_ld", 1'b0, HZ_BR, 12'h000);
      step();
      idle();
      expect_out("br_ld_after", 1'b0, HZ_NONE, 12'h000);
      step();

      // PC write walking down E, M, W.
      bus_a.PCSrcE = 1'b1;
      expect_out("pc_e", 1'b0, HZ_PC, 12'h000);
      step();
      bus_a.PCSrcE = 1'b0;
      bus_a.PCSrcM = 1'b1;
      expect_out("pc_m", 1'b0, HZ_PC, 12'h000);
      step();
      bus_a.PCSrcM = 1'b0;
      bus_a.PCSrcW = 1'b1;
      expect_out("pc_w", 1'b0, HZ_PCW, 12'h000);
      step();
      idle();
      expect_out("pc_done", 1'b0, HZ_NONE, 12'h000);
      step();

      // Let every counter drain before the reset test.
      repeat (6) step();

      // Reset dropped during a dut_b stall with ld_cnt==2.
      load_r7(1'b1);
      expect_out("rst_ld_c0_b", 1'b1, HZ_LD, 12'h000);
      step();
      load_r7(1'b0);
      expect_out("rst_ld_c1_b", 1'b1, HZ_LD, 12'h000);
      step();
      bus_a.SrcRegE[3:0] = 4'd5;
      bus_a.SrcValidE[0] = 1'b1;
      bus_a.DstRegM[3:0] = 4'd5;
      bus_a.RegWriteM    = 2'b01;
      #1;
      reset = 1'b0;
      expect_out("rst_mid_a", 1'b0, HZ_NONE, 12'h000);
      expect_out("rst_mid_b", 1'b1, HZ_NONE, 12'h000);
      step();
      idle();
      reset = 1'b1;
      expect_out("rst_rel_a", 1'b0, HZ_NONE, 12'h000);
      expect_out("rst_rel_b", 1'b1, HZ_NONE, 12'h000);
      step();
      expect_out("rst_rel2_b", 1'b1, HZ_NONE, 12'h000);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_gen2.md
Name: hazard_ctrl_gen2

Overview:
Parametrised second-generation hazard controller for the pipelined core. It compares register addresses itself, so it needs no precomputed match flags. It handles NUM_SRC execute-stage operands against NUM_WP write ports per stage. It adds a multi-cycle load-use stall for slow memory (LD_LAT) and a multi-cycle execute-busy stall for the iterative multiplier (MUL_LAT), both tracked by internal down-counters.

Parameters:
NUM_SRC, 4, number of source operands per instruction (D and E stages)
NUM_WP, 2, register write ports per pipeline stage
REG_AW, 4, register address width
LD_LAT, 1, cycles of load-use stall per dependent load (1..4)
MUL_LAT, 1, execute cycles of a multiply (1..8); 1 means single-cycle with no busy stall
FW, derived = clog2(2*NUM_WP+1), width of each forward select

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
SrcRegD  in  NUM_SRC*REG_AW  decode-stage source addresses
SrcValidD  in  NUM_SRC  per-source valid, decode
SrcRegE  in  NUM_SRC*REG_AW  execute-stage source addresses
SrcValidE  in  NUM_SRC  per-source valid, execute
DstRegE / DstRegM / DstRegW  in  NUM_WP*REG_AW  destination addresses per stage
RegWriteE / RegWriteM / RegWriteW  in  NUM_WP  per-port write enables
MemToRegE  in  1  instruction in E is a load
MulStartE  in  1  multiply entering E this cycle
BranchTakenE  in  1  branch resolved taken in E
PCSrcD / PCSrcE / PCSrcM / PCSrcW  in  1  PC-writing instruction in the stage
ForwardE  out  NUM_SRC*FW  forward select per E operand
StallF / StallD / StallE  out  1  active-high hold
FlushD / FlushE / FlushM  out  1  active-high bubble insert

Behaviour:
- Forward encoding per operand: 0 = register file; port k in M = 2 for k=0, else 2k+1; port k in W = 1 for k=0, else 2k+2. For NUM_WP=2 this gives M0=2, W0=1, M1=3, W1=4.
- Forward priority: k ascending; for each k, M before W. First hit wins.
- A hit requires SrcValidE[i], address equality, and the port's RegWrite.
- Forwarding is purely combinational, with zero latency.
- ldHit = OR over valid D sources and E ports k of (SrcRegD==DstRegE[k] & RegWriteE[k]) & MemToRegE.
- ld_cnt: width clog2(LD_LAT+1), reset 0.
- Load-use on ldHit & ld_cnt==0 & mul_cnt==0 & ~BranchTakenE:
  - Assert StallF, StallD and FlushE this cycle.
  - Load ld_cnt = LD_LAT-1.
  - While ld_cnt>0: assert StallF, StallD, FlushE and decrement. ldHit is ignored.
- mul_cnt: width clog2(MUL_LAT), reset 0.
- Multiply busy on MulStartE & mul_cnt==0 & MUL_LAT>1:
  - Load mul_cnt = MUL_LAT-1.
  - While mul_cnt>0: assert StallF, StallD, StallE and FlushM, then decrement. The first-cycle multiply produces no stall.
- Branch logic:
  - PCWrPend = PCSrcD|PCSrcE|PCSrcM.
  - BrE = BranchTakenE & mul_cnt==0; BranchTakenE is ignored while the multiplier is busy.
  - StallF also asserts on PCWrPend.
  - FlushD = PCWrPend | PCSrcW | BrE.
  - FlushE also asserts on BrE.
- Simultaneous events:
  - Branch + load-use in the same cycle: branch wins. Flush D and E, do not load ld_cnt.
  - mul_cnt>0 with ldHit: the multiply stall dominates, and load-use is evaluated once mul_cnt==0.
  - ld_cnt>0 with MulStartE: the multiply starts only after ld_cnt==0 (E is flushed, so MulStartE is low by construction). The bench asserts this.
- Reset (reset=0, asynchronous) clears both counters immediately. While reset is low, all Stall*, Flush* and ForwardE outputs are forced to 0.
- Reset released mid-stall: the counters restart from 0; there is no residual stall.

Decomposition:
- Package hazard_pkg holds:
  - forward-code constants FWD_RF, FWD_M0, FWD_W0;
  - the function fwd_code(stage, k);
  - the FW clog2 helper.
- One sub-module, hazard_fwd_sel. It is instantiated NUM_SRC times and takes one operand's address/valid against all M/W ports to produce its FW-bit select.

Test Plan:
1. NUM_WP=2; SrcRegE[0]=5 valid; DstRegM[1]=5, RegWriteM=2'b10; DstRegW[0]=5, RegWriteW=2'b01 -> ForwardE[0]=3'b011 (M1 beats W0? no: W0 precedes M1 -> ForwardE[0]=3'b001). Then clear RegWriteW -> ForwardE[0]=3'b011.
2. LD_LAT=3, load to r7 in E, SrcRegD[1]=7 valid -> StallF/StallD/FlushE high for exactly 3 cycles, ld_cnt sequence 2,1,0, then deassert.
3. MUL_LAT=4, MulStartE pulse -> StallF/D/E and FlushM high for cycles 2-4. BranchTakenE pulsed in cycle 3 -> FlushD stays 0.
4. BranchTakenE and ldHit in the same cycle -> FlushD=1, FlushE=1, StallD=0; next cycle all hazard outputs 0.
5. PCSrcE=1 for one cycle, then PCSrcM, then PCSrcW -> StallF high for 2 cycles, FlushD high for 3 cycles.
6. Drop reset during an LD_LAT=4 stall (ld_cnt=2) -> all outputs 0 immediately. After release with no hazard inputs -> no stall.
